bsr_chain: RTL and testbench

BSR_CHAIN -- requirements
Module: bsr_chain

---
 rtl/bsr_chain.sv | 109 ++++++++++
 tb/tb_bsr_chain.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsr_chain.sv
// Boundary-scan register chain: a capture/shift stage feeding a guarded
// parallel update stage, with the latched mode steering core_in and sys_out.
//
// Strobe semantics: capture_dr, shift_dr and update_dr are level strobes
// sampled on each rising tck edge. There is no ready/backpressure. When both
// capture and shift are high, capture wins. An update is accepted only when
// exactly L shifts have happened since the last capture. Acceptance is
// reported one cycle later on upd_ok; rejection on upd_err.
module bsr_chain #(
    parameter int               N_IN     = 3,
    parameter int               N_OUT    = 2,
    parameter logic [N_OUT-1:0] SAFE_OUT = '0,
    localparam int              L        = N_IN + N_OUT,
    localparam int              CW       = $clog2(L + 2)
) (
    input  logic              tck,
    input  logic              trst,
    input  logic              capture_dr,
    input  logic              shift_dr,
    input  logic              update_dr,
    input  logic [1:0]        mode_in,
    input  logic              scan_in,
    output logic              scan_out,
    input  logic [N_IN-1:0]   sys_in,
    output logic [N_IN-1:0]   core_in,
    input  logic [N_OUT-1:0]  core_out,
    output logic [N_OUT-1:0]  sys_out,
    output logic [1:0]        mode,
    output logic [CW-1:0]     shift_cnt,
    output logic              upd_ok,
    output logic              upd_err
);

    typedef enum logic [1:0] {
        FUNC   = 2'b00,
        EXTEST = 2'b01,
        INTEST = 2'b10,
        CLAMP  = 2'b11
    } mode_t;

    logic [L-1:0] cap_q;
    logic [L-1:0] upd_q;
    mode_t        mode_q;
    logic         full_shift;

    // An update is legal only after exactly L shifts since the last capture.
    assign full_shift = (shift_cnt == CW'(L));

    // Capture/shift stage and shift counter; capture has priority over shift.
    always_ff @(posedge tck) begin
        if (trst) begin
            cap_q     <= '0;
            shift_cnt <= '0;
        end else if (capture_dr) begin
            cap_q     <= {core_out, sys_in};
            shift_cnt <= '0;
        end else if (shift_dr) begin
            cap_q <= {cap_q[L-2:0], scan_in};
            if (shift_cnt != CW'(L + 1)) begin
                shift_cnt <= shift_cnt + 1'b1;
            end
        end
    end

    // Guarded update stage: uses the pre-edge capture data and shift count.
    always_ff @(posedge tck) begin
        if (trst) begin
            upd_q   <= {SAFE_OUT, {N_IN{1'b0}}};
            mode_q  <= FUNC;
            upd_ok  <= 1'b0;
            upd_err <= 1'b0;
        end else begin
            upd_ok  <= update_dr && full_shift;
            upd_err <= update_dr && !full_shift;
            if (update_dr && full_shift) begin
                upd_q  <= cap_q;
                mode_q <= mode_t'(mode_in);
            end
        end
    end

    // Pin/core steering from the latched mode; purely combinational.
    always_comb begin
        core_in = sys_in;
        sys_out = core_out;
        unique case (mode_q)
            FUNC: begin
                core_in = sys_in;
                sys_out = core_out;
            end
            EXTEST, CLAMP: begin
                core_in = sys_in;
                sys_out = upd_q[L-1:N_IN];
            end
            INTEST: begin
                core_in = upd_q[N_IN-1:0];
                sys_out = SAFE_OUT;
            end
            default: begin
                core_in = sys_in;
                sys_out = core_out;
            end
        endcase
    end

    assign scan_out = cap_q[L-1];
    assign mode     = mode_q;

endmodule

// File: tb/tb_bsr_chain.sv
// Self-checking bench for bsr_chain using a queue-based reference model.
module tb_bsr_chain;

    localparam int               N_IN  = 3;
    localparam int               N_OUT = 2;
    localparam logic [N_OUT-1:0] SAFE  = 2'b01;
    localparam int               L     = N_IN + N_OUT;
    localparam int               CW    = $clog2(L + 2);
    localparam int               VW    = 1 + N_IN + N_OUT + 2 + CW + 2;

    logic             tck = 1'b0;
    logic             trst;
    logic             capture_dr, shift_dr, update_dr;
    logic [1:0]       mode_in;
    logic             scan_in, scan_out;
    logic [N_IN-1:0]  sys_in, core_in;
    logic [N_OUT-1:0] core_out, sys_out;
    logic [1:0]       mode;
    logic [CW-1:0]    shift_cnt;
    logic             upd_ok, upd_err;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: cq[i] / uq[i] hold cell i.
    bit cq[$];
    bit uq[$];
    int m_mode;
    int m_cnt;
    bit m_ok, m_err;

    bsr_chain #(.N_IN(N_IN), .N_OUT(N_OUT), .SAFE_OUT(SAFE)) dut (
        .tck(tck), .trst(trst), .capture_dr(capture_dr), .shift_dr(shift_dr),
        .update_dr(update_dr), .mode_in(mode_in), .scan_in(scan_in),
        .scan_out(scan_out), .sys_in(sys_in), .core_in(core_in),
        .core_out(core_out), .sys_out(sys_out), .mode(mode),
        .shift_cnt(shift_cnt), .upd_ok(upd_ok), .upd_err(upd_err)
    );

    // Clock
    always #5 tck = ~tck;

    function automatic void model_reset();
        cq.delete();
        uq.delete();
        for (int i = 0; i < L; i++) cq.push_back(1'b0);
        for (int i = 0; i < N_IN; i++) uq.push_back(1'b0);
        for (int j = 0; j < N_OUT; j++) uq.push_back(SAFE[j]);
        m_mode = 0;
        m_cnt  = 0;
        m_ok   = 1'b0;
        m_err  = 1'b0;
    endfunction

    // Expected {scan_out, core_in, sys_out, mode, shift_cnt, upd_ok, upd_err}.
    function automatic logic [VW-1:0] exp_all();
        logic [N_IN-1:0]  ci;
        logic [N_OUT-1:0] so;
        for (int i = 0; i < N_IN; i++) ci[i] = (m_mode == 2) ? uq[i] : sys_in[i];
        for (int j = 0; j < N_OUT; j++)
            so[j] = (m_mode == 0) ? core_out[j] : (m_mode == 2) ? SAFE[j] : uq[N_IN + j];
        return {cq[L-1], ci, so, 2'(m_mode), CW'(m_cnt), m_ok, m_err};
    endfunction

    function automatic logic [VW-1:0] act_all();
        return {scan_out, core_in, sys_out, mode, shift_cnt, upd_ok, upd_err};
    endfunction

    // Driver: apply strobes for one edge, advance the model, settle.
    task automatic step(input bit rst, input bit cap, input bit sh, input bit upd,
                        input logic [1:0] md, input bit si);
        bit tmp[$];
        trst = rst; capture_dr = cap; shift_dr = sh; update_dr = upd;
        mode_in = md; scan_in = si;
        @(posedge tck);
        if (rst) begin
            model_reset();
        end else begin
            m_ok  = upd && (m_cnt == L);
            m_err = upd && (m_cnt != L);
            if (m_ok) begin
                uq = cq;
                m_mode = int'(md);
            end
            if (cap) begin
                tmp.delete();
                for (int i = 0; i < N_IN; i++) tmp.push_back(sys_in[i]);
                for (int j = 0; j < N_OUT; j++) tmp.push_back(core_out[j]);
                cq = tmp;
                m_cnt = 0;
            end else if (sh) begin
                cq.push_front(si);
                void'(cq.pop_back());
                m_cnt = (m_cnt + 1 > L + 1) ? L + 1 : m_cnt + 1;
            end
        end
        #1;
        trst = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
    endtask

    task automatic test_reset();
        sys_in = 3'b101; core_out = 2'b10;
        step(1, 0, 0, 0, 2'b00, 0);
        n_vec++;
        if (core_in !== 3'b101 || sys_out !== 2'b10 || scan_out !== 1'b0 || mode !== 2'b00) begin
            n_err++;
            $display("FAIL reset_func got ci=%b so=%b sout=%b mode=%b exp ci=101 so=10 sout=0 mode=00",
                     core_in, sys_out, scan_out, mode);
        end
        n_vec++;
        if (shift_cnt !== '0 || upd_ok !== 1'b0 || upd_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_cnt got cnt=%0d ok=%b err=%b exp 0 0 0", shift_cnt, upd_ok, upd_err);
        end
    endtask

    task automatic test_scan_out();
        logic [4:0] seq;
        logic [4:0] want;
        want = 5'b11101;
        sys_in = 3'b101; core_out = 2'b11;
        step(0, 1, 0, 0, 2'b00, 0);
        for (int k = 0; k < 5; k++) begin
            seq[4-k] = scan_out;
            step(0, 0, 1, 0, 2'b00, 0);
        end
        n_vec++;
        if (seq !== want) begin
            n_err++;
            $display("FAIL scan_seq got=%b exp=%b", seq, want);
        end
        n_vec++;
        if (shift_cnt !== CW'(5)) begin
            n_err++;
            $display("FAIL scan_cnt got=%0d exp=5", shift_cnt);
        end
    endtask

    task automatic test_extest();
        logic [4:0] bits;
        bits = 5'b01110;
        sys_in = 3'b010; core_out = 2'b11;
        step(0, 1, 0, 0, 2'b00, 0);
        for (int k = 4; k >= 0; k--) step(0, 0, 1, 0, 2'b00, bits[k]);
        step(0, 0, 0, 1, 2'b01, 0);
        n_vec++;
        if (upd_ok !== 1'b1 || upd_err !== 1'b0 || mode !== 2'b01) begin
            n_err++;
            $display("FAIL extest_upd got ok=%b err=%b mode=%b exp 1 0 01", upd_ok, upd_err, mode);
        end
        n_vec++;
        if (sys_out !== 2'b01 || core_in !== sys_in) begin
            n_err++;
            $display("FAIL extest_out got so=%b ci=%b exp so=01 ci=%b", sys_out, core_in, sys_in);
        end
        step(0, 0, 0, 0, 2'b00, 0);
        n_vec++;
        if (upd_ok !== 1'b0) begin
            n_err++;
            $display("FAIL extest_pulse got ok=%b exp 0", upd_ok);
        end
    endtask

    task automatic test_upd_err();
        logic [N_OUT-1:0] so_before;
        logic [1:0]       md_before;
        so_before = sys_out; md_before = mode;
        step(0, 1, 0, 0, 2'b00, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 2'b00, 1);
        step(0, 0, 0, 1, 2'b10, 0);
        n_vec++;
        if (upd_err !== 1'b1 || upd_ok !== 1'b0 || mode !== md_before || sys_out !== so_before) begin
            n_err++;
            $display("FAIL short_upd got err=%b ok=%b mode=%b so=%b exp 1 0 %b %b",
                     upd_err, upd_ok, mode, sys_out, md_before, so_before);
        end
        for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 2'b00, 0);
        n_vec++;
        if (shift_cnt !== CW'(L + 1)) begin
            n_err++;
            $display("FAIL saturate got=%0d exp=%0d", shift_cnt, L + 1);
        end
        step(0, 0, 0, 1, 2'b10, 0);
        n_vec++;
        if (upd_err !== 1'b1 || mode !== md_before) begin
            n_err++;
            $display("FAIL long_upd got err=%b mode=%b exp 1 %b", upd_err, mode, md_before);
        end
    endtask

    task automatic test_cap_shift();
        sys_in = 3'b110; core_out = 2'b01;
        step(0, 1, 1, 0, 2'b00, 1);
        n_vec++;
        if (shift_cnt !== '0 || act_all() !== exp_all()) begin
            n_err++;
            $display("FAIL cap_wins got=%b exp=%b", act_all(), exp_all());
        end
    endtask

    task automatic test_intest_reset();
        logic [4:0] bits;
        bits = 5'b10011;
        step(0, 1, 0, 0, 2'b00, 0);
        for (int k = 4; k >= 0; k--) step(0, 0, 1, 0, 2'b00, bits[k]);
        step(0, 0, 0, 1, 2'b10, 0);
        sys_in = 3'b100; core_out = 2'b10;
        #1;
        n_vec++;
        if (core_in !== 3'b011 || sys_out !== SAFE || mode !== 2'b10) begin
            n_err++;
            $display("FAIL intest got ci=%b so=%b mode=%b exp 011 %b 10", core_in, sys_out, mode, SAFE);
        end
        step(0, 0, 1, 0, 2'b00, 1);
        step(1, 1, 1, 1, 2'b11, 1);
        n_vec++;
        if (mode !== 2'b00 || sys_out !== core_out || core_in !== sys_in || shift_cnt !== '0
            || upd_ok !== 1'b0 || upd_err !== 1'b0 || scan_out !== 1'b0) begin
            n_err++;
            $display("FAIL intest_rst got=%b exp=%b", act_all(), exp_all());
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            sys_in = N_IN'($urandom); core_out = N_OUT'($urandom);
            step(0, 1, $urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom), $urandom_range(0, 1));
            for (int k = 0; k < L + $urandom_range(0, 1) - $urandom_range(0, 1); k++) begin
                core_out = N_OUT'($urandom);
                step(0, 0, 1, 0, 2'b00, $urandom_range(0, 1));
                n_vec++;
                if (act_all() !== exp_all()) begin
                    n_err++;
                    $display("FAIL rand_shift got=%b exp=%b", act_all(), exp_all());
                end
            end
            step(0, 0, $urandom_range(0, 1), 1, 2'($urandom), $urandom_range(0, 1));
            sys_in = N_IN'($urandom); core_out = N_OUT'($urandom);
            #1;
            n_vec++;
            if (act_all() !== exp_all()) begin
                n_err++;
                $display("FAIL rand_upd got=%b exp=%b", act_all(), exp_all());
            end
        end
        for (int it = 0; it < 300; it++) begin
            sys_in = N_IN'($urandom); core_out = N_OUT'($urandom);
            step($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1),
                 $urandom_range(0, 5) == 0, 2'($urandom), $urandom_range(0, 1));
            n_vec++;
            if (act_all() !== exp_all()) begin
                n_err++;
                $display("FAIL rand_free got=%b exp=%b", act_all(), exp_all());
            end
        end
    endtask

    initial begin
        trst = 1'b1; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
        mode_in = 2'b00; scan_in = 1'b0; sys_in = '0; core_out = '0;
        model_reset();
        test_reset();
        test_scan_out();
        test_extest();
        test_upd_err();
        test_cap_shift();
        test_intest_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
